// File: rtl/seg_disp_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment driver.
//   SEG_*      active-high font patterns, bit order {g,f,e,d,c,b,a}
//   seg_font   BCD code -> pattern (codes 10-15 render blank)
//   pow10      10**n, used for the overflow threshold at elaboration
//   clog2      ceil(log2(n)), never below 1 so it can size a vector
package seg_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_font(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int unsigned clog2(input longint unsigned n);
    int unsigned     r = 0;
    longint unsigned v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle.
//   CLK, reset  clock, async active-high reset (aborts a conversion)
//   start       begin conversion of value (honoured only while idle)
//   value       BIN_W-bit binary input
//   busy        conversion in progress, BIN_W cycles from the start edge
//   done        one-cycle pulse in the cycle after the result lands in bcd
//   finish      combinational, high during the last conversion cycle
//   bcd         result register, N_DIGITS BCD digits (upper digits beyond
//               N_DIGITS are dropped; the lower digits stay exact)
module bin2bcd_seq
  import seg_disp_pkg::*;
#(
  parameter int unsigned BIN_W    = 14,
  parameter int unsigned N_DIGITS = 4
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  finish,
  output logic [4*N_DIGITS-1:0] bcd
);

  localparam int unsigned BCD_W = 4 * N_DIGITS;
  localparam int unsigned CW    = clog2(BIN_W + 1);

  logic [BIN_W-1:0] shreg;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] acc_adj;
  logic [BCD_W-1:0] acc_next;
  logic [CW-1:0]    cnt;

  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_next = {acc_adj[BCD_W-2:0], shreg[BIN_W-1]};
  end

  assign finish = busy && (cnt == CW'(1));

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        acc   <= acc_next;
        shreg <= shreg << 1;
        cnt   <= cnt - CW'(1);
        if (finish) begin
          busy <= 1'b0;
          done <= 1'b1;
          bcd  <= acc_next;
        end
      end else if (start) begin
        shreg <= value;
        acc   <= '0;
        cnt   <= CW'(BIN_W);
        busy  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_disp_mux_bcd.sv
// Multiplexed 7-segment display driver with sequential BCD conversion.
//   CLK, reset  100 MHz clock, async active-high reset
//   value       binary value to display, captured by load while !busy
//   dp_mask     decimal point enables, bit 0 = rightmost digit
//   load        capture request
//   busy        conversion running, load ignored
//   done        one-cycle pulse when the new value becomes displayed
//   overflow    displayed value >= 10**N_DIGITS (all digits show dashes)
//   digits      anode enables, bit i = digit i
//   segments    cathodes {g,f,e,d,c,b,a}
//   dp          decimal point cathode
module seg_disp_mux_bcd
  import seg_disp_pkg::*;
#(
  parameter int unsigned N_DIGITS        = 4,
  parameter int unsigned BIN_W           = 14,
  parameter int unsigned TICKS_PER_DIGIT = 262144,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned BLANK_LZ        = 1
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [BIN_W-1:0]    value,
  input  logic [N_DIGITS-1:0] dp_mask,
  input  logic                load,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [N_DIGITS-1:0] digits,
  output logic [6:0]          segments,
  output logic                dp
);

  localparam longint unsigned OVF_LIM  = pow10(N_DIGITS);
  localparam int unsigned     TW       = clog2(TICKS_PER_DIGIT);
  localparam int unsigned     IW       = clog2(N_DIGITS);
  localparam logic [TW-1:0]   TICK_MAX = TW'(TICKS_PER_DIGIT - 1);
  localparam logic [IW-1:0]   IDX_MAX  = IW'(N_DIGITS - 1);
  localparam logic            POL      = (ACTIVE_LOW != 0);

  logic                  start;
  logic                  conv_finish;
  logic [4*N_DIGITS-1:0] bcd_disp;
  logic [N_DIGITS-1:0]   dp_pend, dp_disp;
  logic                  ovf_pend, ovf_disp;
  logic [TW-1:0]         tick;
  logic [IW-1:0]         idx;

  assign start = load && !busy;

  // Display BCD lives in the converter's result register; dp and overflow
  // are staged here and committed on the converter's last cycle so all
  // three change on the same edge.
  bin2bcd_seq #(
    .BIN_W   (BIN_W),
    .N_DIGITS(N_DIGITS)
  ) u_conv (
    .CLK   (CLK),
    .reset (reset),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .finish(conv_finish),
    .bcd   (bcd_disp)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      dp_pend  <= '0;
      ovf_pend <= 1'b0;
      dp_disp  <= '0;
      ovf_disp <= 1'b0;
    end else begin
      if (start) begin
        dp_pend  <= dp_mask;
        ovf_pend <= (64'(value) >= OVF_LIM);
      end
      if (conv_finish) begin
        dp_disp  <= dp_pend;
        ovf_disp <= ovf_pend;
      end
    end
  end

  assign overflow = ovf_disp;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      tick <= '0;
      idx  <= '0;
    end else if (tick == TICK_MAX) begin
      tick <= '0;
      idx  <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
    end else begin
      tick <= tick + TW'(1);
    end
  end

  logic [3:0]          cur_digit;
  logic                cur_dp;
  logic                upper_nz;
  logic                blank;
  logic [N_DIGITS-1:0] an_next;
  logic [6:0]          seg_next;
  logic                dp_next;

  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    upper_nz  = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (IW'(i) == idx) begin
        cur_digit = bcd_disp[4*i +: 4];
        cur_dp    = dp_disp[i];
      end
      if (IW'(i) >= idx && bcd_disp[4*i +: 4] != 4'd0) upper_nz = 1'b1;
    end
    blank = (BLANK_LZ != 0) && !ovf_disp && (idx != '0) && !upper_nz;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      an_next[i] = (IW'(i) == idx) && !blank;
    end
    if (ovf_disp)   seg_next = SEG_DASH;
    else if (blank) seg_next = SEG_BLANK;
    else            seg_next = seg_font(cur_digit);
    dp_next = !ovf_disp && !blank && cur_dp;
  end

  logic [N_DIGITS-1:0] an_q;
  logic [6:0]          seg_q;
  logic                dp_q;

  // Registered active-high; reset value 0 becomes "inactive" after the
  // polarity XOR regardless of ACTIVE_LOW.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      an_q  <= '0;
      seg_q <= '0;
      dp_q  <= 1'b0;
    end else begin
      an_q  <= an_next;
      seg_q <= seg_next;
      dp_q  <= dp_next;
    end
  end

  assign digits   = an_q ^ {N_DIGITS{POL}};
  assign segments = seg_q ^ {7{POL}};
  assign dp       = dp_q ^ POL;

endmodule
